// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns PCF and runs a single-outstanding imem request/ready
// handshake, holding fetched words across decode stalls and dropping redirect-stale responses.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        StallD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_valid,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCF,
  output logic [31:0] Instr,
  output logic        InstrValidF,
  output logic        StallF,
  output logic        BubbleD
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] target_s;
  logic [31:0] pc_inc_s;
  logic        fire_s;
  logic        valid_s;
  logic        deliver_s;

  assign target_s   = PCTargetE & 32'hFFFF_FFFC;
  assign pc_inc_s   = pcf_q + 32'd4;
  assign imem_valid = (state_q == REQ) || (state_q == DISCARD);
  assign imem_addr  = {pcf_q[31:2], 2'b00};
  assign fire_s     = imem_valid & imem_ready;
  assign deliver_s  = valid_s & ~StallD & ~PCSrcE;

  assign PCF         = pcf_q;
  assign InstrValidF = valid_s;
  assign StallF      = ~deliver_s;
  assign BubbleD     = ~valid_s & ~StallD;

  // Next-state, next-PC and offered-instruction logic.
  always_comb begin
    state_d      = state_q;
    pcf_d        = pcf_q;
    hold_instr_d = hold_instr_q;
    pend_pc_d    = pend_pc_q;
    valid_s      = 1'b0;
    Instr        = NOP_INSTR;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (PCSrcE) begin
          pcf_d = target_s;
        end else begin
          pcf_d = pcf_q;
        end
      end
      REQ: begin
        if (PCSrcE) begin
          // Redirect wins; an unanswered request must finish at its old address first.
          if (fire_s) begin
            pcf_d = target_s;
          end else begin
            pend_pc_d = target_s;
            state_d   = DISCARD;
          end
        end else if (fire_s) begin
          valid_s = 1'b1;
          Instr   = imem_rdata;
          if (StallD) begin
            hold_instr_d = imem_rdata;
            state_d      = HOLD;
          end else begin
            pcf_d = pc_inc_s;
          end
        end else begin
          state_d = REQ;
        end
      end
      HOLD: begin
        if (PCSrcE) begin
          pcf_d   = target_s;
          state_d = REQ;
        end else begin
          valid_s = 1'b1;
          Instr   = hold_instr_q;
          if (!StallD) begin
            pcf_d   = pc_inc_s;
            state_d = REQ;
          end else begin
            state_d = HOLD;
          end
        end
      end
      DISCARD: begin
        if (fire_s) begin
          pcf_d   = PCSrcE ? target_s : pend_pc_q;
          state_d = REQ;
        end else if (PCSrcE) begin
          pend_pc_d = target_s;
        end else begin
          state_d = DISCARD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      pcf_q        <= RESET_PC;
      hold_instr_q <= NOP_INSTR;
      pend_pc_q    <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      pcf_q        <= pcf_d;
      hold_instr_q <= hold_instr_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: word-address memory model, per-cycle output checks and a
// scoreboard of expected (PCF, Instr) deliveries popped whenever the DUT delivers.
module tb_fetch_ctrl;

  logic        clk;
  logic        resetn;
  logic        StallD;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] PCF;
  logic [31:0] Instr;
  logic        InstrValidF;
  logic        StallF;
  logic        BubbleD;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb_q[$];
  int   total;
  int   fails;

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .resetn(resetn), .StallD(StallD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .PCF(PCF), .Instr(Instr), .InstrValidF(InstrValidF),
    .StallF(StallF), .BubbleD(BubbleD)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0000_0020) ? 32'h00A0_0093 : a;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    sb_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pcf"},   PCF, 32'h0000_0000);
    chk({tag, "_valid"}, {31'd0, imem_valid}, 32'd0);
    chk({tag, "_ivf"},   {31'd0, InstrValidF}, 32'd0);
    chk({tag, "_instr"}, Instr, NOP);
    chk({tag, "_stallf"}, {31'd0, StallF}, 32'd1);
    chk({tag, "_bubble"}, {31'd0, BubbleD}, 32'd1);
  endtask

  // One cycle: drive at negedge, check at negedge+1, pop the scoreboard on a delivery.
  task automatic step(input logic stall, input logic pcsrc, input logic [31:0] tgt,
                      input logic rdy, input logic exp_valid, input logic [31:0] exp_addr,
                      input logic exp_ivf);
    exp_t e;
    @(negedge clk);
    StallD     = stall;
    PCSrcE     = pcsrc;
    PCTargetE  = tgt;
    imem_ready = rdy;
    #1;
    chk("imem_valid", {31'd0, imem_valid}, {31'd0, exp_valid});
    if (exp_valid) chk("imem_addr", imem_addr, exp_addr);
    chk("ivf", {31'd0, InstrValidF}, {31'd0, exp_ivf});
    chk("stallf", {31'd0, StallF}, {31'd0, ~(exp_ivf & ~stall & ~pcsrc)});
    chk("bubbled", {31'd0, BubbleD}, {31'd0, ~exp_ivf & ~stall});
    if (!exp_ivf) chk("nop_instr", Instr, NOP);
    if (InstrValidF && !StallF) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_delivery_pc", PCF, 32'hDEAD_BEEF);
      end else begin
        e = sb_q.pop_front();
        chk("sb_pcf", PCF, e.pc);
        chk("sb_instr", Instr, e.instr);
      end
    end
  endtask

  task automatic sb_drained(input string tag);
    chk(tag, sb_q.size(), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    total      = 0;
    fails      = 0;
    resetn     = 1'b0;
    StallD     = 1'b0;
    PCSrcE     = 1'b0;
    PCTargetE  = 32'h0;
    imem_ready = 1'b1;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    resetn = 1'b1;

    // Zero-wait streaming from the reset PC.
    for (int i = 0; i < 4; i++) push(32'(i * 4), 32'(i * 4));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'(i * 4), 1'b1);
    sb_drained("stream_drained");

    // Three wait states at 0x10.
    push(32'h10, 32'h10);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h10, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 1'b1);
    for (int i = 5; i < 8; i++) push(32'(i * 4), 32'(i * 4));
    for (int i = 5; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'(i * 4), 1'b1);
    sb_drained("wait_drained");

    // Decode stall holds 0x00A00093 fetched at 0x20.
    push(32'h20, 32'h00A0_0093);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("hold_instr", Instr, 32'h00A0_0093);
    chk("hold_pcf", PCF, 32'h20);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 9; i < 16; i++) push(32'(i * 4), 32'(i * 4));
    for (int i = 9; i < 16; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'(i * 4), 1'b1);
    sb_drained("hold_drained");

    // Redirect to 0x100 while the request at 0x40 waits two cycles.
    step(1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 32'h40, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 1'b0);
    push(32'h100, 32'h100);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 1'b1);

    // Newest redirect in DISCARD wins.
    step(1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 32'h104, 1'b0);
    step(1'b0, 1'b1, 32'h200, 1'b0, 1'b1, 32'h104, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h104, 1'b0);
    push(32'h200, 32'h200);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 1'b1);
    sb_drained("redirect_drained");

    // Redirect coincident with fire, low target bits ignored, then PC wrap.
    step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h204, 1'b0);
    push(32'hFFFF_FFFC, 32'hFFFF_FFFC);
    push(32'h0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1);
    sb_drained("wrap_drained");

    // Redirect out of HOLD drops the held word.
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 1'b1);
    step(1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 32'h0, 1'b0);
    push(32'h300, 32'h300);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h300, 1'b1);
    sb_drained("hold_redirect_drained");

    // Asynchronous reset in the middle of HOLD.
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h304, 1'b1);
    @(negedge clk);
    StallD = 1'b0;
    #1;
    chk("hold_before_reset", {31'd0, InstrValidF}, 32'd1);
    #1;
    resetn = 1'b0;
    #1;
    check_reset_outputs("midhold_reset");
    @(negedge clk);
    resetn = 1'b1;
    push(32'h0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1);
    sb_drained("final_drained");

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer that owns the fetch-stage program counter (PCF) and drives the single-outstanding instruction-memory request/ready handshake. It feeds `fetch_stage` with `Instr`, `PCF` and a stall/bubble pair, and applies branch/jump redirects from execute. It holds fetched instructions across decode stalls and discards responses made stale by a redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: PCF value after reset.
- `NOP_INSTR`, default 32'h0000_0013 (addi x0,x0,0): value on `Instr` when no valid instruction is available.

- `clk`  in  1: clock; all state updates on the rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `StallD`  in  1: the decode register must hold; an instruction cannot be delivered this cycle.
- `PCSrcE`  in  1: redirect request from execute.
- `PCTargetE`  in  32: redirect target address.
- `imem_valid`  out  1: instruction-memory request.
- `imem_addr`  out  32: request address, equal to {PCF[31:2],2'b00}.
- `imem_ready`  in  1: memory accepts the request; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32: instruction word.
- `PCF`  out  32: fetch PC of the instruction currently offered.
- `Instr`  out  32: instruction offered to `fetch_stage`.
- `InstrValidF`  out  1: `Instr` is a real, non-discarded instruction.
- `StallF`  out  1: drives `fetch_stage` Stall; equals !deliver.
- `BubbleD`  out  1: inject a NOP into decode; equals !InstrValidF & !StallD.

## Operation
- States: IDLE, REQ, HOLD, DISCARD. Registers: PCF, hold_instr, pend_pc.
- Definitions:
  - fire = imem_valid & imem_ready.
  - deliver = InstrValidF & !StallD & !PCSrcE.
- IDLE: the only state entered by reset. imem_valid=0. Next edge: go to REQ. If PCSrcE=1, also PCF←PCTargetE.
- REQ: imem_valid=1 and imem_addr=PCF. Both hold stable until fire.
  - !fire and PCSrcE: pend_pc←PCTargetE, go to DISCARD.
  - fire and PCSrcE: drop the data, PCF←PCTargetE, stay in REQ.
  - fire, !PCSrcE, !StallD: InstrValidF=1, Instr=imem_rdata, PCF←PCF+4, stay in REQ.
  - fire, !PCSrcE, StallD: InstrValidF=1, hold_instr←imem_rdata, go to HOLD. PCF does not change.
- HOLD: imem_valid=0, Instr=hold_instr, InstrValidF=1.
  - PCSrcE: drop the held instruction, PCF←PCTargetE, go to REQ.
  - Otherwise, when !StallD: deliver, PCF←PCF+4, go to REQ.
- DISCARD: imem_valid=1 with the old PCF (the address must not change while a request is outstanding). InstrValidF=0.
  - PCSrcE in this state: pend_pc←PCTargetE (the newest redirect wins).
  - On fire: drop the data, then PCF←(PCSrcE ? PCTargetE : pend_pc), go to REQ.
- PCSrcE has priority over StallD and over delivery. When PCSrcE=1 in any state, InstrValidF=0.
- When InstrValidF=0, Instr=NOP_INSTR.
- Arithmetic and alignment:
  - PCF+4 is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC → 0).
  - PCTargetE[1:0] is ignored (forced to 0). Misalignment is not flagged.

## Timing
- Reset (asynchronous, takes effect immediately): PCF=RESET_PC, state=IDLE, imem_valid=0, InstrValidF=0, Instr=NOP_INSTR, StallF=1, BubbleD=1, hold_instr=NOP_INSTR, pend_pc=0.
- Reset asserted mid-request: imem_valid drops immediately. Any in-flight response is ignored.
- First imem_valid: the cycle after the first rising edge with resetn high.
- With zero-wait memory (imem_ready always 1), throughput is one instruction per cycle. Instr is combinational from imem_rdata.
- A redirect costs one bubble with ready memory. During DISCARD it costs the remaining wait cycles plus one.
- A wait state (imem_ready=0) gives StallF=1 and BubbleD=!StallD for each such cycle.
- A delivery out of HOLD needs no memory cycle. The next request starts in the following cycle.

## Test plan
- Reset release, RESET_PC=0, imem_ready=1, memory returns its word address → imem_addr is 0,4,8,C on consecutive cycles; InstrValidF=1 from the first request cycle; StallF=0.
- imem_ready low for 3 cycles at address 0x10 → imem_addr stays 0x10; BubbleD=1 for 3 cycles; the instruction is delivered on the 4th cycle; PCF then advances to 0x14.
- StallD high for 2 cycles while word 0x00A00093 is returned at 0x20 → enter HOLD with imem_valid=0; Instr=0x00A00093 held; delivered when StallD falls; next imem_addr=0x24.
- PCSrcE=1, PCTargetE=0x100 while the request at 0x40 waits 2 cycles → address stays 0x40 until fire; data is dropped (InstrValidF=0); next imem_addr=0x100.
- Second redirect to 0x200 during DISCARD (after an earlier one to 0x100) → the next request goes to 0x200, not 0x100.
- PCF=32'hFFFF_FFFC delivered → PCF wraps to 0. Separately, assert resetn low mid-HOLD → outputs return to their reset values immediately.
